// File: rtl/round_sequencer.sv
// Two-player bell-reaction card game sequencer: deals two pseudo-random cards per round,
// counts down round time, scores the first valid bell press and tracks completed rounds.
module round_sequencer #(
  parameter logic [7:0] ROUND_TIME = 8'd20,
  parameter logic [3:0] MAX_ROUNDS = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic [3:0] keypad_in,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic [2:0] n1,
  output logic [2:0] n2,
  output logic [7:0] count,
  output logic [1:0] who,
  output logic [3:0] round,
  output logic       game_over
);

  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned RND_W = 4;

  localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] S_DEAL    = 3'd1;
  localparam logic [ST_W-1:0] S_WAIT    = 3'd2;
  localparam logic [ST_W-1:0] S_SCORE   = 3'd3;
  localparam logic [ST_W-1:0] S_RELEASE = 3'd4;
  localparam logic [ST_W-1:0] S_NEXT    = 3'd5;
  localparam logic [ST_W-1:0] S_DONE    = 3'd6;

  localparam logic [3:0] KEY_A = 4'b0111;
  localparam logic [3:0] KEY_B = 4'b1001;
  localparam logic [1:0] WHO_A = 2'b01;
  localparam logic [1:0] WHO_B = 2'b10;

  logic [ST_W-1:0]  state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [1:0]       c1_q, c1_d, c2_q, c2_d;
  logic [2:0]       n1_q, n1_d, n2_q, n2_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       who_q, who_d;
  logic [1:0]       player_q, player_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             over_q, over_d;

  logic             press_a_c, press_b_c;
  logic [RND_W-1:0] round_inc_c;

  // Maps a 3-bit value onto a card number 1..5 ((v mod 5) + 1).
  function automatic logic [2:0] card_num(input logic [2:0] v);
    if (v >= 3'd5) return 3'(v - 3'd4);
    else           return 3'(v + 3'd1);
  endfunction

  assign press_a_c   = (keypad_in == KEY_A);
  assign press_b_c   = (keypad_in == KEY_B);
  assign round_inc_c = RND_W'(round_q + 4'd1);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    c1_d     = c1_q;
    c2_d     = c2_q;
    n1_d     = n1_q;
    n2_d     = n2_q;
    count_d  = count_q;
    player_d = player_q;
    round_d  = round_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DEAL;
          round_d = '0;
        end
      end
      S_DEAL: begin
        c1_d    = lfsr_q[1:0];
        c2_d    = lfsr_q[3:2];
        n1_d    = card_num(lfsr_q[6:4]);
        n2_d    = card_num(lfsr_q[7:5] ^ lfsr_q[2:0]);
        count_d = ROUND_TIME;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A press wins over a simultaneous tick and over timeout.
        if (press_a_c || press_b_c) begin
          player_d = press_a_c ? WHO_A : WHO_B;
          state_d  = S_SCORE;
        end else if (count_q == '0) begin
          state_d = S_NEXT;
        end else if (tick) begin
          count_d = CNT_W'(count_q - 8'd1);
        end
      end
      S_SCORE: state_d = S_RELEASE;
      S_RELEASE: begin
        if (!(press_a_c || press_b_c)) state_d = S_NEXT;
      end
      S_NEXT: begin
        round_d = round_inc_c;
        state_d = (round_inc_c == MAX_ROUNDS) ? S_DONE : S_DEAL;
      end
      S_DONE: begin
        if (start) begin
          state_d = S_DEAL;
          round_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    who_d  = (state_d == S_SCORE) ? player_d : 2'b00;
    over_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= 8'hA5;
      c1_q     <= '0;
      c2_q     <= '0;
      n1_q     <= '0;
      n2_q     <= '0;
      count_q  <= '0;
      who_q    <= '0;
      player_q <= '0;
      round_q  <= '0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      n1_q     <= n1_d;
      n2_q     <= n2_d;
      count_q  <= count_d;
      who_q    <= who_d;
      player_q <= player_d;
      round_q  <= round_d;
      over_q   <= over_d;
    end
  end

  assign c1        = c1_q;
  assign c2        = c2_q;
  assign n1        = n1_q;
  assign n2        = n2_q;
  assign count     = count_q;
  assign who       = who_q;
  assign round     = round_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: a per-cycle vector table for one scored round
// plus hand-written sequences for timeout, press/tick collision, game end and async reset.
module tb_round_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       tick;
  logic [3:0] keypad_in;
  logic [1:0] c1, c2, who;
  logic [2:0] n1, n2;
  logic [7:0] count;
  logic [3:0] round;
  logic       game_over;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_lfsr;
  logic [7:0] dl;

  round_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .keypad_in(keypad_in),
    .c1(c1), .c2(c2), .n1(n1), .n2(n2), .count(count), .who(who),
    .round(round), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference LFSR, polynomial x^8+x^6+x^5+x^4+1, seed A5.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
  end

  typedef struct packed {
    logic       tick;
    logic [3:0] key;
    logic [1:0] who;
    logic [7:0] count;
    logic [3:0] round;
    logic       go;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic t, input logic [3:0] k, input logic [1:0] w,
                              input logic [7:0] c, input logic [3:0] r, input logic g);
    vec_t v;
    v.tick = t; v.key = k; v.who = w; v.count = c; v.round = r; v.go = g;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic [3:0] k, input logic s);
    tick = t; keypad_in = k; start = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] exp_cards(input logic [7:0] l);
    int a, b;
    a = (int'(l[6:4]) % 5) + 1;
    b = (int'(l[7:5] ^ l[2:0]) % 5) + 1;
    return {l[1:0], l[3:2], 3'(a), 3'(b)};
  endfunction

  task automatic chk_cards(input string nm);
    chk(nm, 32'({c1, c2, n1, n2}), 32'(exp_cards(dl)));
    chk({nm, "_n1_range"}, 32'(n1 >= 3'd1 && n1 <= 3'd5), 32'd1);
    chk({nm, "_n2_range"}, 32'(n2 >= 3'd1 && n2 <= 3'd5), 32'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; tick = 1'b0; keypad_in = 4'h0;
    dl = 8'h00;

    tbl[0]  = mk(1'b1, 4'h0, 2'b00, 8'd19, 4'd0, 1'b0);
    tbl[1]  = mk(1'b1, 4'h0, 2'b00, 8'd18, 4'd0, 1'b0);
    tbl[2]  = mk(1'b1, 4'h0, 2'b00, 8'd17, 4'd0, 1'b0);
    tbl[3]  = mk(1'b1, 4'h0, 2'b00, 8'd16, 4'd0, 1'b0);
    tbl[4]  = mk(1'b1, 4'h0, 2'b00, 8'd15, 4'd0, 1'b0);
    tbl[5]  = mk(1'b0, 4'h7, 2'b01, 8'd15, 4'd0, 1'b0);
    for (int i = 6; i < 16; i++)
      tbl[i] = mk(1'(i % 2), 4'h7, 2'b00, 8'd15, 4'd0, 1'b0);
    tbl[16] = mk(1'b0, 4'h0, 2'b00, 8'd15, 4'd0, 1'b0);
    tbl[17] = mk(1'b1, 4'h7, 2'b00, 8'd15, 4'd1, 1'b0);
    tbl[18] = mk(1'b0, 4'h9, 2'b00, 8'd20, 4'd1, 1'b0);
    tbl[19] = mk(1'b0, 4'h0, 2'b00, 8'd20, 4'd1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({c1, c2, n1, n2, count, who, round, game_over}), 32'd0);
    rst = 1'b1;

    cyc(1'b0, 4'h7, 1'b0);
    chk("idle_ignores_key", 32'({who, count}), 32'd0);
    cyc(1'b0, 4'h0, 1'b1);
    dl = m_lfsr;
    chk("deal_round_cleared", 32'({round, game_over}), 32'd0);
    cyc(1'b0, 4'h0, 1'b0);
    chk("first_deal_count", 32'(count), 32'd20);
    chk_cards("first_deal_cards");

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].tick, tbl[i].key, 1'b0);
      if (i == 17) dl = m_lfsr;
      chk($sformatf("vec%0d", i), 32'({who, count, round, game_over}),
          32'({tbl[i].who, tbl[i].count, tbl[i].round, tbl[i].go}));
    end
    chk_cards("round1_cards");

    for (int k = 1; k <= 20; k++) begin
      cyc(1'b1, 4'h0, 1'b0);
      chk($sformatf("timeout_tick%0d", k), 32'({who, count}), 32'({2'b00, 8'(20 - k)}));
    end
    cyc(1'b1, 4'h0, 1'b0);
    chk("timeout_next", 32'({who, count, round}), 32'({2'b00, 8'd0, 4'd1}));
    cyc(1'b0, 4'h0, 1'b0);
    dl = m_lfsr;
    chk("timeout_deal_round", 32'({who, round}), 32'({2'b00, 4'd2}));
    cyc(1'b0, 4'h0, 1'b0);
    chk("round2_count", 32'(count), 32'd20);
    chk_cards("round2_cards");

    repeat (13) cyc(1'b1, 4'h0, 1'b0);
    chk("collide_pre_count", 32'(count), 32'd7);
    cyc(1'b1, 4'h9, 1'b0);
    chk("collide_score", 32'({who, count}), 32'({2'b10, 8'd7}));
    cyc(1'b1, 4'h0, 1'b0);
    chk("collide_release", 32'({who, count}), 32'({2'b00, 8'd7}));
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    dl = m_lfsr;
    chk("collide_deal_round", 32'(round), 32'd3);
    cyc(1'b0, 4'h0, 1'b0);
    chk("round3_count", 32'(count), 32'd20);

    for (int r = 3; r <= 9; r++) begin
      cyc(1'b0, 4'h7, 1'b0);
      chk($sformatf("fast_score_r%0d", r), 32'({who, count}), 32'({2'b01, 8'd20}));
      cyc(1'b0, 4'h0, 1'b0);
      cyc(1'b0, 4'h0, 1'b0);
      cyc(1'b0, 4'h0, 1'b0);
      if (r < 9) dl = m_lfsr;
      chk($sformatf("fast_round_r%0d", r), 32'({round, game_over}),
          32'({4'(r + 1), 1'(r == 9)}));
      if (r < 9) cyc(1'b0, 4'h0, 1'b0);
    end

    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, (k == 1) ? 4'h9 : 4'h7, 1'b0);
      chk($sformatf("done_hold%0d", k), 32'({who, count, round, game_over}),
          32'({2'b00, 8'd20, 4'd10, 1'b1}));
      chk_cards($sformatf("done_cards%0d", k));
    end
    cyc(1'b0, 4'h0, 1'b1);
    dl = m_lfsr;
    chk("restart_deal", 32'({round, game_over}), 32'({4'd0, 1'b0}));
    cyc(1'b0, 4'h0, 1'b0);
    chk("restart_count", 32'(count), 32'd20);
    chk_cards("restart_cards");

    repeat (3) cyc(1'b1, 4'h0, 1'b0);
    chk("pre_reset_count", 32'(count), 32'd17);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({c1, c2, n1, n2, count, who, round, game_over}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 4'h7, 1'b0);
      chk($sformatf("post_reset_idle%0d", k), 32'({who, count, round, game_over}), 32'd0);
    end
    cyc(1'b0, 4'h0, 1'b1);
    dl = m_lfsr;
    cyc(1'b0, 4'h0, 1'b0);
    chk("post_reset_count", 32'(count), 32'd20);
    chk_cards("post_reset_cards");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
